// File: rtl/matrix_pkg.sv
// Shared types and constants for the 2x2 matrix operand loader.
package matrix_pkg;

    localparam int ELEM_W = 9;
    localparam int N_ELEM = 4;
    localparam int MAT_W  = ELEM_W * N_ELEM;

    // Element count value meaning "operand complete"
    localparam logic [2:0] CNT_FULL = 3'd4;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        CALC   = 2'd2
    } loader_state_t;

    // Element index shown to the user: the count itself, pinned to 3 once full
    function automatic logic [1:0] idx_of_cnt(input logic [2:0] cnt);
        logic [1:0] idx;
        if (cnt == CNT_FULL) begin
            idx = 2'd3;
        end else begin
            idx = cnt[1:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/matrix_loader_if.sv
// Handshake and operand bus between the key front end, the loader and the
// calculation unit. Signal names match the loader's external contract.
interface matrix_loader_if;
    import matrix_pkg::*;

    logic [ELEM_W-1:0] keycode;
    logic              store_dig;
    logic              enter;
    logic              result_ready;
    logic              calc_done;
    logic [MAT_W-1:0]  mat_a;
    logic [MAT_W-1:0]  mat_b;
    logic [1:0]        elem_idx;
    logic              operand_sel;
    logic              calc_start;
    logic              busy;
    logic              err;

    // Driver side (key encoder / calc unit as seen from outside the loader)
    modport master (
        output keycode, store_dig, enter, result_ready, calc_done,
        input  mat_a, mat_b, elem_idx, operand_sel, calc_start, busy, err
    );

    // Loader side
    modport slave (
        input  keycode, store_dig, enter, result_ready, calc_done,
        output mat_a, mat_b, elem_idx, operand_sel, calc_start, busy, err
    );
endinterface

// File: rtl/matrix_reg_bank.sv
// 4 x 9-bit element store with indexed write and synchronous clear.
// Element k appears at data_o[9k+8:9k].
module matrix_reg_bank
    import matrix_pkg::*;
(
    input  logic              clk,
    input  logic              clr_i,
    input  logic              we_i,
    input  logic [1:0]        idx_i,
    input  logic [ELEM_W-1:0] wdata_i,
    output logic [MAT_W-1:0]  data_o
);

    logic [ELEM_W-1:0] mem_q [N_ELEM];

    // Element storage: clear wins, otherwise write the addressed element
    always_ff @(posedge clk) begin
        if (clr_i) begin
            for (int k = 0; k < N_ELEM; k++) begin
                mem_q[k] <= '0;
            end
        end else if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    // Flatten the element array into the row-major bus layout
    always_comb begin
        data_o = '0;
        for (int k = 0; k < N_ELEM; k++) begin
            data_o[k*ELEM_W +: ELEM_W] = mem_q[k];
        end
    end

endmodule

// File: rtl/matrix_loader.sv
// Matrix operand loader: collects two 2x2 operands element by element from
// key pulses, then hands them to the calculation unit and waits for it.
// Optional build macro: MATRIX_LOADER_OVERWRITE_EN -- a store on a full
// operand wraps and overwrites element 0 instead of being rejected.
module matrix_loader
    import matrix_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    matrix_loader_if.slave  bus
);

    loader_state_t state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          calc_start_q;
    logic          busy_q;
    logic          operand_sel_q;
    logic [1:0]    elem_idx_q;

    logic          we_a_s;
    logic          we_b_s;
    logic [1:0]    widx_s;

    // Next-state decode; store_dig outranks enter, which outranks result_ready
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        we_a_s  = 1'b0;
        we_b_s  = 1'b0;
        widx_s  = cnt_q[1:0];
        case (state_q)
            LOAD_A, LOAD_B: begin
                if (bus.store_dig) begin
                    if (cnt_q != CNT_FULL) begin
                        we_a_s = (state_q == LOAD_A);
                        we_b_s = (state_q == LOAD_B);
                        cnt_d  = cnt_q + 3'd1;
                    end else begin
`ifdef MATRIX_LOADER_OVERWRITE_EN
                        we_a_s = (state_q == LOAD_A);
                        we_b_s = (state_q == LOAD_B);
                        widx_s = 2'd0;
                        cnt_d  = 3'd1;
`else
                        err_d  = 1'b1;
`endif
                    end
                end else if (bus.enter) begin
                    if ((state_q == LOAD_A) && (cnt_q == CNT_FULL)) begin
                        state_d = LOAD_B;
                        cnt_d   = 3'd0;
                    end else begin
                        err_d   = 1'b1;
                    end
                end else if (bus.result_ready) begin
                    if ((state_q == LOAD_B) && (cnt_q == CNT_FULL)) begin
                        state_d = CALC;
                    end else begin
                        err_d   = 1'b1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            CALC: begin
                if (bus.calc_done) begin
                    state_d = LOAD_A;
                    cnt_d   = 3'd0;
                end else begin
                    state_d = CALC;
                end
            end
            default: begin
                state_d = LOAD_A;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // State, count and all status outputs registered from the decoded next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= LOAD_A;
            cnt_q         <= 3'd0;
            err_q         <= 1'b0;
            calc_start_q  <= 1'b0;
            busy_q        <= 1'b0;
            operand_sel_q <= 1'b0;
            elem_idx_q    <= 2'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            calc_start_q  <= (state_d == CALC) && (state_q != CALC);
            busy_q        <= (state_d == CALC);
            operand_sel_q <= (state_d == LOAD_B);
            elem_idx_q    <= idx_of_cnt(cnt_d);
        end
    end

    matrix_reg_bank u_bank_a (
        .clk     (clk),
        .clr_i   (rst),
        .we_i    (we_a_s),
        .idx_i   (widx_s),
        .wdata_i (bus.keycode),
        .data_o  (bus.mat_a)
    );

    matrix_reg_bank u_bank_b (
        .clk     (clk),
        .clr_i   (rst),
        .we_i    (we_b_s),
        .idx_i   (widx_s),
        .wdata_i (bus.keycode),
        .data_o  (bus.mat_b)
    );

    assign bus.err         = err_q;
    assign bus.calc_start  = calc_start_q;
    assign bus.busy        = busy_q;
    assign bus.operand_sel = operand_sel_q;
    assign bus.elem_idx    = elem_idx_q;

endmodule

// File: doc/matrix_loader.md
MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 SHALL have these ports, clock and reset first (name  direction  width  meaning):
- clk  in  1  single system clock, rising-edge.
- rst  in  1  reset; synchronous, active-high.
- keycode  in  9  element value from the key encoder; valid when store_dig=1.
- store_dig  in  1  one-cycle pulse: write keycode as the next element.
- enter  in  1  one-cycle pulse: close operand A and start operand B.
- result_ready  in  1  one-cycle pulse: request the calculation.
- calc_done  in  1  level or pulse from the calculation unit: computation finished.
- mat_a  out  36  operand A, 2x2, row-major; element k at bits [9k+8:9k].
- mat_b  out  36  operand B, same layout.
- elem_idx  out  2  index of the next element to write.
- operand_sel  out  1  0 = filling A, 1 = filling B.
- calc_start  out  1  one-cycle pulse to the calculation unit.
- busy  out  1  high while waiting for calc_done.
- err  out  1  one-cycle pulse on a rejected or illegal input.

REQ-002 SHALL use one clock domain; reset is synchronous and active-high.

Function
REQ-003 SHALL implement FSM states LOAD_A, LOAD_B and CALC.
REQ-004 SHALL hold a 3-bit element count cnt (0..4); elem_idx = cnt[1:0] while cnt<4, and 3 when cnt=4.
REQ-005 store_dig in LOAD_A/LOAD_B with cnt<4 SHALL write keycode to element cnt of the current operand and increment cnt; the new value is visible on mat_a/mat_b in the next cycle.
REQ-006 enter in LOAD_A with cnt=4 SHALL go to LOAD_B and clear cnt; enter in LOAD_A with cnt<4 SHALL pulse err and stay in LOAD_A.
REQ-007 enter in LOAD_B SHALL be ignored and SHALL pulse err.
REQ-008 result_ready in LOAD_B with cnt=4 SHALL go to CALC; result_ready in any other case SHALL pulse err and change no state.
REQ-009 calc_start SHALL be high for exactly the first cycle in CALC; busy SHALL be high for every cycle in CALC.
REQ-010 calc_done in any CALC cycle, including the first, SHALL return the FSM to LOAD_A with cnt=0; calc_done outside CALC SHALL be ignored.
REQ-011 In CALC, store_dig, enter and result_ready SHALL be ignored without err; mat_a and mat_b SHALL hold.
REQ-012 Simultaneous inputs SHALL be resolved by priority store_dig > enter > result_ready; the lower-priority inputs are dropped without err.
REQ-013 Matrices SHALL keep their contents across the return to LOAD_A; each element is replaced only when rewritten.
REQ-014 operand_sel SHALL be 1 exactly in LOAD_B; all outputs SHALL be registered.

Reset
REQ-015 rst=1 at a clock edge SHALL set: state LOAD_A, cnt 0, mat_a 0, mat_b 0, calc_start 0, busy 0, err 0, operand_sel 0.
REQ-016 rst SHALL take priority over all inputs, including in mid-CALC; no calc_start is issued after reset until a new complete A/B load.

Configuration
REQ-017 Macro MATRIX_LOADER_OVERWRITE_EN:
- Defined: store_dig at cnt=4 SHALL wrap, overwrite element 0, set cnt=1 and give no err.
- Undefined: store_dig at cnt=4 SHALL be dropped, SHALL pulse err, and cnt stays at 4.

Structure
REQ-018 Package matrix_pkg SHALL hold ELEM_W=9, N_ELEM=4 and the loader_state_t enum (LOAD_A, LOAD_B, CALC).
REQ-019 Sub-module matrix_reg_bank (4x9 register bank with write-enable, index and synchronous clear) SHALL be instantiated twice, once for A and once for B.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Four store_dig pulses with keycodes 0x001, 0x0FF, 0x100, 0x1FF -> mat_a=={0x1FF,0x100,0x0FF,0x001} (element 3 in the MSBs), elem_idx=3.
- enter after 2 elements -> err pulse for 1 cycle, operand_sel stays 0; after 2 more elements, enter -> operand_sel=1 the next cycle.
- Full A and B, then result_ready -> calc_start=1 for exactly 1 cycle, busy=1 until calc_done; calc_done then gives state LOAD_A, busy=0.
- Fifth store_dig with keycode 0x055 -> with OVERWRITE_EN: element 0=0x055 and err=0; without: mat_a unchanged and err=1.
- rst asserted 2 cycles into CALC -> all outputs 0 the next cycle; a later calc_done has no effect.
- store_dig and enter in the same cycle at cnt=3 -> element 3 written, cnt=4, state stays LOAD_A, no err.
